// File: rtl/xdom_rdout_ctrl.sv
// ---------------------------------------------------------------------------
// xdom_rdout_ctrl
//
// Multi-buffer readout controller. N_BUFS readout buffers form a circular
// queue: the waveform reader fills the tail buffer and commits it with a run
// pulse, while the host drains the head buffer over the CRS register bus and
// releases it by writing "done". Readout therefore keeps running while the
// host is still reading an earlier event.
//
// Optional feature macro: XDOM_RDOUT_CHECKSUM_EN
//   defined   -> per-buffer 16-bit wrapping checksum, readable at 0xEFB
//   undefined -> no checksum logic, 0xEFB is unmapped
//
// Parameters
//   N_BUFS     number of buffers (power of 2, 2..8)
//   BUF_ADR_W  32-bit word address width per buffer (<= 10)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   y_adr/y_wr/y_wr_data  CRS bus address, write strobe, write data
//   y_rd_data, y_rd_hit   registered CRS read data / in-map flag
//   rdout_dpram_wren      write strobe into the tail buffer
//   rdout_dpram_wr_addr   word address in the tail buffer
//   rdout_dpram_data      32-bit write data
//   rdout_dpram_run       one-cycle commit pulse for the tail buffer
//   dpram_len_in          length of the buffer being committed
//   dpram_busy            all buffers full (combinational)
//   n_full                number of full buffers
//
// Register map (reads registered, one cycle latency)
//   0xEFF R  len[hd] (0 when empty)
//   0xEFE W  bit0 = done      R {15'b0, n_full != 0}
//   0xEFD R  {ovf_cnt, 1'b0, hd[2:0], n_full[3:0]}
//   0xEFC W  clear ovf_cnt    R {8'b0, N_BUFS[7:0]}
//   0xEFB R  sum[hd] (checksum build only)
//   0x000-0x7FF R  head buffer, 16-bit view; y_adr[0] picks the half
// ---------------------------------------------------------------------------
module xdom_rdout_ctrl #(
  parameter int N_BUFS    = 2,
  parameter int BUF_ADR_W = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   y_adr,
  input  logic                          y_wr,
  input  logic [15:0]                   y_wr_data,
  output logic [15:0]                   y_rd_data,
  output logic                          y_rd_hit,
  input  logic                          rdout_dpram_wren,
  input  logic [BUF_ADR_W-1:0]          rdout_dpram_wr_addr,
  input  logic [31:0]                   rdout_dpram_data,
  input  logic                          rdout_dpram_run,
  input  logic [15:0]                   dpram_len_in,
  output logic                          dpram_busy,
  output logic [$clog2(N_BUFS+1)-1:0]   n_full
);

  localparam int PW    = $clog2(N_BUFS);
  localparam int CW    = $clog2(N_BUFS+1);
  localparam int DEPTH = 1 << BUF_ADR_W;
  localparam logic [CW-1:0] NB = CW'(N_BUFS);

  localparam logic [11:0] A_LEN  = 12'hEFF;
  localparam logic [11:0] A_DONE = 12'hEFE;
  localparam logic [11:0] A_STAT = 12'hEFD;
  localparam logic [11:0] A_OVF  = 12'hEFC;
  localparam logic [11:0] A_SUM  = 12'hEFB;

  // ---------------------------------------------------------------------
  // queue state
  // ---------------------------------------------------------------------
  logic [PW-1:0]              hd_q, hd_d;
  logic [PW-1:0]              tl_q, tl_d;
  logic [CW-1:0]              n_full_q, n_full_d;
  logic [7:0]                 ovf_q, ovf_d;
  logic [N_BUFS-1:0][15:0]    len_q, len_d;

  logic done_req, done_acc, run_acc, wr_acc, ovf_clr, not_empty;

  assign not_empty  = (n_full_q != '0);
  assign dpram_busy = (n_full_q == NB);
  assign n_full     = n_full_q;

  assign done_req = y_wr & (y_adr == A_DONE) & y_wr_data[0];
  assign ovf_clr  = y_wr & (y_adr == A_OVF);
  assign done_acc = done_req & not_empty;
  // A done in the same cycle frees a slot, so a run is taken even when full.
  assign run_acc  = rdout_dpram_run & (~dpram_busy | done_acc);
  assign wr_acc   = rdout_dpram_wren & ~dpram_busy;

  always_comb begin
    hd_d     = hd_q;
    tl_d     = tl_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    // done is applied first: when full, hd == tl and the freshly committed
    // length must survive the clear of the released buffer.
    if (done_acc) begin
      len_d[hd_q] = '0;
      hd_d        = hd_q + 1'b1;
    end
    if (run_acc) begin
      len_d[tl_q] = dpram_len_in;
      tl_d        = tl_q + 1'b1;
    end
    n_full_d = n_full_q + CW'(run_acc) - CW'(done_acc);
    if (ovf_clr)
      ovf_d = '0;
    else if (rdout_dpram_run && !run_acc && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q     <= '0;
      tl_q     <= '0;
      n_full_q <= '0;
      ovf_q    <= '0;
      len_q    <= '0;
    end else begin
      hd_q     <= hd_d;
      tl_q     <= tl_d;
      n_full_q <= n_full_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
    end
  end

`ifdef XDOM_RDOUT_CHECKSUM_EN
  // ---------------------------------------------------------------------
  // per-buffer checksum: wrapping sum of both halves of each accepted word
  // ---------------------------------------------------------------------
  logic [N_BUFS-1:0][15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (wr_acc)
      sum_d[tl_q] = sum_q[tl_q] + rdout_dpram_data[15:0] + rdout_dpram_data[31:16];
    // The released buffer is next filled only once it becomes tail, so
    // clearing at release time is equivalent. Skip the clear when a run in
    // the same cycle recommits that very buffer.
    if (done_acc && !(run_acc && hd_q == tl_q))
      sum_d[hd_q] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  // ---------------------------------------------------------------------
  // buffer RAM: one write port (tail), one synchronous read port (head)
  // ---------------------------------------------------------------------
  logic [31:0] mem [N_BUFS][DEPTH];
  logic [31:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[tl_q][rdout_dpram_wr_addr] <= rdout_dpram_data;
    // read uses the pre-edge head, so a read alongside done sees the old head
    rd_word_q <= mem[hd_q][y_adr[BUF_ADR_W:1]];
  end

  // ---------------------------------------------------------------------
  // register read path
  // ---------------------------------------------------------------------
  logic [15:0] reg_rd_q, reg_rd_d;
  logic        hit_q, hit_d;
  logic        ram_sel_q, ram_sel_d;
  logic        half_q;

  always_comb begin
    reg_rd_d  = '0;
    hit_d     = 1'b0;
    ram_sel_d = 1'b0;
    if (!y_adr[11]) begin
      hit_d     = 1'b1;
      ram_sel_d = 1'b1;
    end else begin
      unique case (y_adr)
        A_LEN:  begin hit_d = 1'b1; reg_rd_d = len_q[hd_q]; end
        A_DONE: begin hit_d = 1'b1; reg_rd_d = {15'b0, not_empty}; end
        A_STAT: begin
          hit_d    = 1'b1;
          reg_rd_d = {ovf_q, 1'b0, 3'(hd_q), 4'(n_full_q)};
        end
        A_OVF:  begin hit_d = 1'b1; reg_rd_d = {8'b0, 8'(N_BUFS)}; end
`ifdef XDOM_RDOUT_CHECKSUM_EN
        A_SUM:  begin hit_d = 1'b1; reg_rd_d = sum_q[hd_q]; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rd_q  <= '0;
      hit_q     <= 1'b0;
      ram_sel_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      reg_rd_q  <= reg_rd_d;
      hit_q     <= hit_d;
      ram_sel_q <= ram_sel_d;
      half_q    <= y_adr[0];
    end
  end

  // Half-word select after the RAM register keeps the RAM read port clean;
  // every term is a register so the output is still registered data.
  assign y_rd_data = ram_sel_q ? (half_q ? rd_word_q[31:16] : rd_word_q[15:0])
                               : reg_rd_q;
  assign y_rd_hit  = hit_q;

  // only bit 0 of the write data carries meaning (done)
  logic unused_wdata;
  assign unused_wdata = ^y_wr_data[15:1];

endmodule
